// File: rtl/obi_arb_pkg.sv
// Shared types and constants for the OBI round-robin arbiter.
package obi_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_t;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;
  localparam int          OBI_BE_WIDTH  = 4;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner select: first requester after i_last, wrapping.
module rr_picker #(
  parameter int NUM_MASTERS = 2
) (
  input  logic [NUM_MASTERS-1:0]                              i_req,
  input  logic [((NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1)-1:0] i_last,
  output logic [((NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1)-1:0] o_winner,
  output logic                                                o_any_req
);
  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  function automatic int wrap_idx(input logic [LW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
    return s;
  endfunction

  // Scan farthest-to-nearest so the nearest requester after i_last is the last write.
  always_comb begin
    o_winner  = '0;
    o_any_req = 1'b0;
    for (int off = NUM_MASTERS; off >= 1; off--) begin
      if (i_req[wrap_idx(i_last, off)]) begin
        o_winner  = LW'(wrap_idx(i_last, off));
        o_any_req = 1'b1;
      end
    end
  end
endmodule

// File: rtl/obi_rr_arbiter.sv
// N-master to 1-slave OBI arbiter, round-robin, one outstanding transaction.
// Optional response watchdog enabled by defining OBI_ARB_TIMEOUT_EN.
module obi_rr_arbiter
  import obi_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_MASTERS-1:0]             m_req_i,
  output logic [NUM_MASTERS-1:0]             m_gnt_o,
  output logic [NUM_MASTERS-1:0]             m_rvalid_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_addr_i,
  input  logic [NUM_MASTERS-1:0]             m_we_i,
  input  logic [NUM_MASTERS*OBI_BE_WIDTH-1:0] m_be_i,
  input  logic [NUM_MASTERS*32-1:0]          m_wdata_i,
  output logic [31:0]                        m_rdata_o,
  output logic                               s_req_o,
  input  logic                               s_gnt_i,
  output logic [ADDR_WIDTH-1:0]              s_addr_o,
  output logic                               s_we_o,
  output logic [OBI_BE_WIDTH-1:0]            s_be_o,
  output logic [31:0]                        s_wdata_o,
  input  logic                               s_rvalid_i,
  input  logic [31:0]                        s_rdata_i,
  output logic                               err_o
);
  localparam int LW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_t      r_state;
  logic [LW-1:0]   r_owner;
  logic [LW-1:0]   r_last;
  logic [LW-1:0]   w_winner;
  logic            w_any_req;
  logic            w_timeout;
  logic            w_resp_done;

  logic [ADDR_WIDTH-1:0]   w_addr  [NUM_MASTERS];
  logic [OBI_BE_WIDTH-1:0] w_be    [NUM_MASTERS];
  logic [31:0]             w_wdata [NUM_MASTERS];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign w_addr[gi]  = m_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_be[gi]    = m_be_i[gi*OBI_BE_WIDTH +: OBI_BE_WIDTH];
    assign w_wdata[gi] = m_wdata_i[gi*32 +: 32];
  end

  rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .i_req     (m_req_i),
    .i_last    (r_last),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

`ifdef OBI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  assign w_timeout = (r_state == RESP) && !s_rvalid_i && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_resp_done = s_rvalid_i || w_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= LW'(NUM_MASTERS - 1);
`ifdef OBI_ARB_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_state <= REQ;
          end
        end
        REQ: begin
          // Owner withdrawing before grant abandons the slot without a transfer.
          if (!m_req_i[r_owner]) begin
            r_state <= IDLE;
          end else if (s_gnt_i) begin
            r_state <= RESP;
`ifdef OBI_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        RESP: begin
          if (w_resp_done) begin
            if (w_any_req) begin
              r_owner <= w_winner;
              r_last  <= w_winner;
              r_state <= REQ;
            end else begin
              r_state <= IDLE;
            end
          end
`ifdef OBI_ARB_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_req_o    = 1'b0;
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_be_o     = '0;
    s_wdata_o  = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = s_rdata_i;
    err_o      = w_timeout;
    case (r_state)
      REQ: begin
        s_req_o            = m_req_i[r_owner];
        s_addr_o           = w_addr[r_owner];
        s_we_o             = m_we_i[r_owner];
        s_be_o             = w_be[r_owner];
        s_wdata_o          = w_wdata[r_owner];
        m_gnt_o[r_owner]   = s_gnt_i && m_req_i[r_owner];
      end
      RESP: begin
        m_rvalid_o[r_owner] = w_resp_done;
        if (w_timeout) m_rdata_o = TIMEOUT_RDATA;
      end
      default: ;
    endcase
  end
endmodule
